// File: rtl/bird_pkg.sv
// Shared types and default constants for the bird controller.
// State encodings and physics defaults used by bird_ctrl and its bench.
package bird_pkg;

   typedef enum logic [1:0] {
      BIRD_INI  = 2'd0,
      BIRD_PLAY = 2'd1,
      BIRD_DEAD = 2'd2
   } bird_state_t;

   localparam logic [9:0] X_POS_DEF    = 10'd160;
   localparam int         Y_W_DEF      = 9;
   localparam int         V_W_DEF      = 8;
   localparam int         Y_INIT_DEF   = 240;
   localparam int         Y_MIN_DEF    = 0;
   localparam int         Y_MAX_DEF    = 440;
   localparam int         GRAVITY_DEF  = 1;
   localparam int         FLAP_VEL_DEF = 6;
   localparam int         VMAX_DEF     = 8;
   localparam int         FRAMES_DEF   = 4;
   localparam int         ANIM_DIV_DEF = 4;

endpackage

// File: rtl/bird_anim_seq.sv
// Wing animation sequencer: tick divider feeding a modulo frame counter.
// init forces frame 1, freeze holds both counters, run enables stepping.
module bird_anim_seq
   import bird_pkg::*;
#(
   parameter int FRAMES   = FRAMES_DEF,
   parameter int ANIM_DIV = ANIM_DIV_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_tick,
   input  logic                        i_run,
   input  logic                        i_freeze,
   input  logic                        i_init,
   output logic [$clog2(FRAMES)-1:0]   o_frame
);

   localparam int FW = $clog2(FRAMES);
   localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

   localparam logic [FW-1:0] C_FONE  = 1;
   localparam logic [FW-1:0] C_FLAST = FW'(FRAMES - 1);
   localparam logic [CW-1:0] C_CONE  = 1;
   localparam logic [CW-1:0] C_CLAST = CW'(ANIM_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic [FW-1:0] r_frame;

   // Divide ticks by ANIM_DIV and advance the frame on each wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_frame <= C_FONE;
      end else if (i_init) begin
         r_cnt   <= '0;
         r_frame <= C_FONE;
      end else if (i_run && i_tick && !i_freeze) begin
         if (r_cnt == C_CLAST) begin
            r_cnt   <= '0;
            r_frame <= (r_frame == C_FLAST) ? '0 : r_frame + C_FONE;
         end else begin
            r_cnt <= r_cnt + C_CONE;
         end
      end
   end

   assign o_frame = r_frame;

endmodule

// File: rtl/bird_ctrl.sv
// Bird controller: play state, vertical physics with clamping, flap latch.
// Wing animation is delegated to bird_anim_seq.
module bird_ctrl
   import bird_pkg::*;
#(
   parameter logic [9:0] X_POS    = X_POS_DEF,
   parameter int         Y_W      = Y_W_DEF,
   parameter int         V_W      = V_W_DEF,
   parameter int         Y_INIT   = Y_INIT_DEF,
   parameter int         Y_MIN    = Y_MIN_DEF,
   parameter int         Y_MAX    = Y_MAX_DEF,
   parameter int         GRAVITY  = GRAVITY_DEF,
   parameter int         FLAP_VEL = FLAP_VEL_DEF,
   parameter int         VMAX     = VMAX_DEF,
   parameter int         FRAMES   = FRAMES_DEF,
   parameter int         ANIM_DIV = ANIM_DIV_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        tick,
   input  logic                        playing,
   input  logic                        flap,
   input  logic                        hit,
   output logic [9:0]                  x,
   output logic [Y_W-1:0]              y,
   output logic [1:0]                  bird_state,
   output logic [$clog2(FRAMES)-1:0]   bird_animation,
   output logic                        dead
);

   localparam int YW2 = Y_W + 2;
   localparam int VW1 = V_W + 1;

   localparam logic [Y_W-1:0]        C_YINIT = Y_W'(Y_INIT);
   localparam logic [Y_W-1:0]        C_YMINU = Y_W'(Y_MIN);
   localparam logic [Y_W-1:0]        C_YMAXU = Y_W'(Y_MAX);
   localparam logic signed [YW2-1:0] C_YMIN  = YW2'(Y_MIN);
   localparam logic signed [YW2-1:0] C_YMAX  = YW2'(Y_MAX);
   localparam logic signed [VW1-1:0] C_GRAV  = VW1'(GRAVITY);
   localparam logic signed [VW1-1:0] C_VMAX  = VW1'(VMAX);
   localparam logic signed [V_W-1:0] C_FLAPV = V_W'(-FLAP_VEL);

   bird_state_t            r_state;
   bird_state_t            w_state_n;
   logic [Y_W-1:0]         r_y;
   logic [Y_W-1:0]         w_y_n;
   logic signed [V_W-1:0]  r_vel;
   logic signed [V_W-1:0]  w_vel_n;
   logic                   r_pend;
   logic                   w_pend_n;
   logic                   r_flap_q;
   logic                   r_dead;

   logic                   w_flap_edge;
   logic signed [VW1-1:0]  w_vel_ext;
   logic signed [VW1-1:0]  w_vel_grav;
   logic signed [V_W-1:0]  w_vel_tick;
   logic signed [YW2-1:0]  w_y_ext;
   logic signed [YW2-1:0]  w_vel_wide;
   logic signed [YW2-1:0]  w_ny;

   assign w_flap_edge = flap & ~r_flap_q;

   assign w_vel_ext  = {r_vel[V_W-1], r_vel};
   assign w_vel_grav = w_vel_ext + C_GRAV;
   assign w_vel_tick = r_pend ? C_FLAPV :
                       (w_vel_grav > C_VMAX) ? C_VMAX[V_W-1:0] :
                       w_vel_grav[V_W-1:0];

   assign w_y_ext    = {2'b00, r_y};
   assign w_vel_wide = {{(YW2-V_W){w_vel_tick[V_W-1]}}, w_vel_tick};
   assign w_ny       = w_y_ext + w_vel_wide;

   // Next state, physics step and flap latch
   always_comb begin
      w_state_n = r_state;
      w_y_n     = r_y;
      w_vel_n   = r_vel;
      w_pend_n  = r_pend;
      unique case (r_state)
         BIRD_INI: begin
            if (playing) w_state_n = BIRD_PLAY;
         end
         BIRD_PLAY: begin
            if (!playing) begin
               w_state_n = BIRD_INI;
            end else if (hit) begin
               w_state_n = BIRD_DEAD;
            end else if (tick) begin
               w_pend_n = w_flap_edge;
               if (w_ny >= C_YMAX) begin
                  w_y_n     = C_YMAXU;
                  w_vel_n   = '0;
                  w_state_n = BIRD_DEAD;
               end else if (w_ny < C_YMIN) begin
                  w_y_n   = C_YMINU;
                  w_vel_n = '0;
               end else begin
                  w_y_n   = w_ny[Y_W-1:0];
                  w_vel_n = w_vel_tick;
               end
            end else begin
               w_pend_n = r_pend | w_flap_edge;
            end
         end
         BIRD_DEAD: begin
            if (!playing) w_state_n = BIRD_INI;
         end
         default: w_state_n = BIRD_INI;
      endcase
      // leaving PLAY drops any pending flap
      if (w_state_n != BIRD_PLAY) w_pend_n = 1'b0;
      // INI (and entry into it) pins the bird at its start position
      if (w_state_n == BIRD_INI) begin
         w_y_n   = C_YINIT;
         w_vel_n = '0;
      end
   end

   // State, physics and edge-detect registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= BIRD_INI;
         r_y      <= C_YINIT;
         r_vel    <= '0;
         r_pend   <= 1'b0;
         r_flap_q <= 1'b0;
         r_dead   <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_y      <= w_y_n;
         r_vel    <= w_vel_n;
         r_pend   <= w_pend_n;
         r_flap_q <= flap;
         r_dead   <= (w_state_n == BIRD_DEAD) && (r_state != BIRD_DEAD);
      end
   end

   bird_anim_seq #(
      .FRAMES   (FRAMES),
      .ANIM_DIV (ANIM_DIV)
   ) u_anim (
      .clk      (clk),
      .rst      (rst),
      .i_tick   (tick),
      .i_run    (r_state == BIRD_PLAY),
      .i_freeze (hit | ~playing),
      .i_init   (w_state_n == BIRD_INI),
      .o_frame  (bird_animation)
   );

   assign x          = X_POS;
   assign y          = r_y;
   assign bird_state = r_state;
   assign dead       = r_dead;

endmodule

// File: tb/tb_bird_ctrl.sv
// Scoreboard bench for bird_ctrl with default parameters.
// Stimulus queues expected outputs; a negedge monitor pops and compares.
module tb_bird_ctrl;

   logic       clk;
   logic       rst;
   logic       tick;
   logic       playing;
   logic       flap;
   logic       hit;
   logic [9:0] x;
   logic [8:0] y;
   logic [1:0] bird_state;
   logic [1:0] bird_animation;
   logic       dead;

   typedef struct packed {
      logic [8:0] y;
      logic [1:0] st;
      logic [1:0] fr;
      logic       d;
   } exp_t;

   exp_t  q[$];
   string tags[$];
   exp_t  e;
   string t;
   int    checks = 0;
   int    errors = 0;

   bird_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .tick           (tick),
      .playing        (playing),
      .flap           (flap),
      .hit            (hit),
      .x              (x),
      .y              (y),
      .bird_state     (bird_state),
      .bird_animation (bird_animation),
      .dead           (dead)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: compare one queued expectation per falling edge
   always @(negedge clk) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         t = tags.pop_front();
         checks++;
         if (y !== e.y || bird_state !== e.st || bird_animation !== e.fr ||
             dead !== e.d || x !== 10'd160) begin
            errors++;
            $display("FAIL %s: got y=%0d st=%0d fr=%0d dead=%0d x=%0d, want y=%0d st=%0d fr=%0d dead=%0d x=160",
                     t, y, bird_state, bird_animation, dead, x, e.y, e.st, e.fr, e.d);
         end
      end
   end

   task automatic expect_out(input string tag, input int ey, input int es,
                             input int ef, input int ed);
      exp_t v;
      v.y  = 9'(ey);
      v.st = 2'(es);
      v.fr = 2'(ef);
      v.d  = 1'(ed);
      q.push_back(v);
      tags.push_back(tag);
   endtask

   task automatic cyc(input logic tk, input logic fl, input logic ht,
                      input logic pl);
      tick    = tk;
      flap    = fl;
      hit     = ht;
      playing = pl;
      @(posedge clk);
      #1;
      tick = 1'b0;
      hit  = 1'b0;
   endtask

   task automatic tk(input bit with_flap);
      if (with_flap) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b1);
         cyc(1'b0, 1'b0, 1'b0, 1'b1);
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   int ff_y[16]  = '{241, 243, 246, 250, 255, 261, 268, 276,
                     284, 292, 300, 308, 316, 324, 332, 340};
   int ff_fr[16] = '{1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0, 0, 0, 0, 1};

   initial begin
      rst = 1'b1; tick = 1'b0; playing = 1'b0; flap = 1'b0; hit = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      expect_out("reset", 240, 0, 1, 0);

      // flap behaviour
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("enter_play", 240, 1, 1, 0);
      for (int i = 0; i < 5; i++) begin
         tk(0);
         expect_out("fall", ff_y[i], 1, ff_fr[i], 0);
      end
      tk(1);
      expect_out("flap_255", 249, 1, 2, 0);
      tk(0);
      expect_out("after_flap", 244, 1, 2, 0);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      expect_out("two_edges", 238, 1, 3, 0);
      tk(0);
      expect_out("single_flap", 233, 1, 3, 0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      expect_out("edge_on_tick", 229, 1, 3, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      expect_out("edge_next_tick", 223, 1, 3, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("to_ini", 240, 0, 1, 0);

      // free fall, animation and ground
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("play2", 240, 1, 1, 0);
      for (int i = 0; i < 16; i++) begin
         tk(0);
         expect_out("anim_fall", ff_y[i], 1, ff_fr[i], 0);
      end
      for (int i = 16; i < 27; i++) tk(0);
      tk(0);
      expect_out("y436", 436, 1, 0, 0);
      tk(0);
      expect_out("ground", 440, 2, 0, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("dead_pulse_end", 440, 2, 0, 0);
      tk(1);
      expect_out("dead_flap", 440, 2, 0, 0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1);
      expect_out("dead_hit", 440, 2, 0, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("dead_to_ini", 240, 0, 1, 0);

      // ceiling clamp
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      tk(0);
      tk(0);
      expect_out("ceil_pre", 243, 1, 1, 0);
      for (int k = 3; k <= 42; k++) tk(1);
      expect_out("y3", 3, 1, 3, 0);
      tk(1);
      expect_out("ceiling", 0, 1, 3, 0);
      tk(0);
      expect_out("vel_zeroed", 1, 1, 0, 0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      expect_out("hit_and_stop", 240, 0, 1, 0);

      // hit together with tick
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 11; i++) tk(0);
      expect_out("y300", 300, 1, 3, 0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1);
      expect_out("hit_tick", 300, 2, 3, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      expect_out("hit_hold", 300, 2, 3, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("hit_to_ini", 240, 0, 1, 0);

      // asynchronous reset mid-play
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) tk(0);
      expect_out("pre_reset", 255, 1, 2, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      #1 rst = 1'b1;
      #1 expect_out("async_reset", 240, 0, 1, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      playing = 1'b0;

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, want finish before 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bird_ctrl.md
# bird_ctrl

Parametrised bird controller for the Flappy Bird game: owns the bird's play state, vertical physics and wing animation. It runs on the system clock and is advanced by a one-cycle frame `tick`. It takes `playing`, `flap` and `hit` from the game top and the collision checker, and drives the bird position and sprite frame to the VGA renderer. It replaces the fixed four-frame, position-less bird state block with gravity, flap, ground/ceiling clamping and a DEAD state.

## Interface
- `X_POS`, 10'd160: constant bird x coordinate.
- `Y_W`, 9: width of y.
- `V_W`, 8: width of signed velocity.
- `Y_INIT`, 240: y in INI and after reset.
- `Y_MIN`, 0: ceiling clamp.
- `Y_MAX`, 440: ground line; reaching it kills the bird.
- `GRAVITY`, 1: velocity increment per tick.
- `FLAP_VEL`, 6: magnitude of upward velocity set by a flap.
- `VMAX`, 8: terminal downward velocity.
- `FRAMES`, 4: animation frame count, at least 2.
- `ANIM_DIV`, 4: ticks per animation frame, at least 1.
- `clk` in, 1: system clock.
- `rst` in, 1: asynchronous, active-high reset.
- `tick` in, 1: one-cycle frame-rate strobe.
- `playing` in, 1: game running (level).
- `flap` in, 1: flap button (level, already debounced).
- `hit` in, 1: pipe collision from the collision checker (level).
- `x` out, 10: equals `X_POS` (constant).
- `y` out, `Y_W`: bird top y.
- `bird_state` out, 2: INI=0, PLAY=1, DEAD=2.
- `bird_animation` out, clog2(FRAMES): sprite frame index.
- `dead` out, 1: one-cycle pulse on entry to DEAD.

## Operation
- **States.**
  - INI → PLAY when `playing`=1.
  - PLAY → INI when `playing`=0. This has priority over all other events.
  - PLAY → DEAD when `hit`=1 in any cycle, or when a tick update gives y ≥ `Y_MAX`.
  - DEAD → INI when `playing`=0.
  - DEAD ignores `flap`, `hit` and `tick`.
- **INI.** Each cycle forces y=`Y_INIT`, vel=0, frame=1, anim counter=0, flap_pending=0.
- **Flap latch.** A rising edge of `flap` (previous `flap` registered) sets flap_pending, but only in PLAY. flap_pending is cleared when consumed and whenever the state is not PLAY. Several edges between ticks count as one flap.
- **Physics on tick in PLAY.**
  - If flap_pending: vel_n = −`FLAP_VEL`.
  - Otherwise: vel_n = min(vel + `GRAVITY`, `VMAX`).
  - ny = y + vel_n, computed signed at `Y_W`+2 bits with both operands sign-extended.
  - If ny ≥ `Y_MAX`: y=`Y_MAX`, vel=0, go to DEAD.
  - Else if ny < `Y_MIN`: y=`Y_MIN`, vel=0.
  - Otherwise: y=ny, vel=vel_n.
- **Animation in PLAY.** On each tick the counter increments. When it reaches `ANIM_DIV`−1 it wraps to 0 and the frame advances by one modulo `FRAMES`. In DEAD, frame and counter are frozen.
- **Simultaneous events.**
  - `hit` and tick in the same cycle: go to DEAD, and y/vel keep their pre-tick values.
  - `hit` and flap edge: DEAD wins.
  - `playing`=0 together with anything: INI.

## Timing
- All outputs are registered. Reset values: y=`Y_INIT`, bird_state=INI, bird_animation=1, dead=0. Internally vel=0, flap_pending=0, counter=0.
- State change is visible the cycle after the cause. A tick's y update is visible the cycle after tick.
- `dead` is high for exactly the first cycle in which bird_state=DEAD.
- A flap edge at least one cycle before a tick affects that tick. An edge in the same cycle as the tick applies to the following tick.
- `rst` asserted mid-game returns all registers to their reset values immediately, without waiting for `clk`.

## Structure
- Shared package `bird_pkg` holds:
  - the state encodings BIRD_INI, BIRD_PLAY, BIRD_DEAD;
  - the default physics constants.
- Sub-module `bird_anim_seq` contains the tick divider and the frame counter, with inputs run/freeze/init.
- Physics and the state machine stay in `bird_ctrl`.

## Test plan
All scenarios use default parameters.
- **Reset.** Assert `rst` mid-PLAY → y=240, state=INI, frame=1, dead=0 asynchronously.
- **Free fall.** `playing`=1, 5 ticks with no flap → vel 1..5, y=241, 243, 246, 250, 255. Continued ticks hold vel at 8.
- **Flap.** Flap edge then tick at y=255 → y=249. Next tick → y=244 (vel −5). Two edges before one tick → a single flap.
- **Ground.** Fall from y=436 with vel 8 → y=440, state=DEAD, one-cycle `dead`. Later ticks and flaps leave y and frame unchanged.
- **Ceiling and hit.**
  - Flap at y=3 → y=0, vel=0.
  - `hit` together with tick at y=300 → DEAD with y=300.
  - `playing`=0 in the same cycle as `hit` → INI.
- **Animation.** 16 ticks in PLAY → frames 1,2,3,0,1 advancing every 4 ticks. Returning to INI → frame 1.
